muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair and replaces the single-cycle HiLo path beside the EXU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the execute stage and runs multiplies through a configurable-depth pipeline and divides through a one-bit-per-cycle restoring divider. A busy/done handshake lets the pipeline stall on HI/LO use, and a cancel input aborts in-flight work on flush.

---
 rtl/muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Multiplies complete after MUL_STAGES cycles; divides use a restoring divider
// that retires one quotient bit per cycle (WIDTH cycles, or 1 cycle for b=0).
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   start, op     request valid and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                 4 MTHI, 5 MTLO, 6-7 reserved no-op)
//   a, b          operands, latched on the accept edge
//   cancel        aborts an in-flight mul/div and blocks a same-cycle start
//   busy, done    operation in progress / one-cycle completion pulse
//   hi, lo        HI and LO registers
module muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx, quot_nx, q_res, r_res;
  logic               acc_sgn;

  // Datapath: full-width product (sign- or zero-extended) and one divider step
  always_comb begin
    mul_a   = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    mul_b   = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = mul_a * mul_b;
    // quot_q doubles as the dividend shift register; its MSB feeds the remainder
    shifted = {rem_q, quot_q[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_q});
    rem_nx  = ge ? WIDTH'(shifted - {1'b0, b_q}) : shifted[WIDTH-1:0];
    quot_nx = {quot_q[WIDTH-2:0], ge};
    q_res   = qneg_q ? -quot_nx : quot_nx;
    r_res   = rneg_q ? -rem_nx  : rem_nx;
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    acc_sgn = (op == OP_DIV);

    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              a_d     = a;
              b_d     = b;
              sgn_d   = (op == OP_MULT);
              cnt_d   = '0;
              state_d = S_MUL;
              busy_d  = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
              // Divide on magnitudes; signs are reapplied at write-back
              a_d     = a;
              b_d     = (acc_sgn && b[WIDTH-1]) ? -b : b;
              quot_d  = (acc_sgn && a[WIDTH-1]) ? -a : a;
              rem_d   = '0;
              qneg_d  = acc_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d  = acc_sgn && a[WIDTH-1];
              div0_d  = (b == '0);
              cnt_d   = '0;
              state_d = S_DIV;
              busy_d  = 1'b1;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
          hi_d    = prod[2*WIDTH-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DIV: begin
        if (cancel) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (div0_q) begin
          hi_d    = a_q;
          lo_d    = '1;
          done_d  = 1'b1;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = r_res;
            lo_d    = q_res;
            done_d  = 1'b1;
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_STAGES=2).
// Expected {hi,lo} results are queued when a request is driven and popped
// when done is observed.
module tb_muldiv_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned MS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         cancel;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  // Reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    int q, r;
    case (o)
      3'd0: return longint'($signed(x)) * longint'($signed(y));
      3'd1: return {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      3'd3: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Drive one request for a single cycle; returns 1ns after the accept edge
  task automatic do_issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Bounded wait for done; n counts edges after the call point
  task automatic wait_done(input int max, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (n < max && !got) begin
      @(posedge clk); #1;
      n++;
      if (done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (hi !== 32'h0)  begin n_fail++; $display("FAIL reset_hi got=%h exp=0", hi); end
    n_checks++; if (lo !== 32'h0)  begin n_fail++; $display("FAIL reset_lo got=%h exp=0", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Issue a mul/div whose expected result was already queued, then check it
  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int lat);
    int n; bit got; logic [2*W-1:0] e;
    do_issue(o, x, y);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy got=%b exp=1", name, busy); end
    wait_done(lat + 8, n, got);
    n_checks++;
    if (!got || n != lat) begin
      n_fail++; $display("FAIL %s_latency got=%0d done=%b exp=%0d", name, n, got, lat);
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_done got=%b exp=0", name, busy); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    n_checks++;
    if ({hi, lo} !== e) begin
      n_fail++; $display("FAIL %s_result got=%h_%h exp=%h_%h", name, hi, lo, e[63:32], e[31:0]);
    end
  endtask

  task automatic test_mult;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5, MS);
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MS);
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got=%b exp=0", done); end
  endtask

  task automatic test_div;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, W);
    exp_q.push_back({32'd2, 32'd14});
    run_op("divu", 3'd3, 32'd100, 32'd7, W);
    exp_q.push_back({32'h0, 32'h8000_0000});
    run_op("div_min", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, W);
  endtask

  task automatic test_div0;
    exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
    run_op("div0", 3'd2, 32'h1234_5678, 32'h0, 1);
  endtask

  task automatic test_mt_cancel;
    int n; bit got;
    do_issue(3'd4, 32'hA, 32'h0);
    n_checks++; if (hi !== 32'hA || busy !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL mthi got hi=%h busy=%b done=%b exp hi=a busy=0 done=0", hi, busy, done); end
    do_issue(3'd5, 32'hB, 32'h0);
    n_checks++; if (lo !== 32'hB || hi !== 32'hA || done !== 1'b0)
      begin n_fail++; $display("FAIL mtlo got hi=%h lo=%h done=%b exp hi=a lo=b done=0", hi, lo, done); end
    // start together with cancel in IDLE must be rejected
    cancel = 1'b1;
    do_issue(3'd4, 32'h55, 32'h0);
    cancel = 1'b0;
    n_checks++; if (hi !== 32'hA || busy !== 1'b0)
      begin n_fail++; $display("FAIL cancel_idle got hi=%h busy=%b exp hi=a busy=0", hi, busy); end
    do_issue(3'd3, 32'd9, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy got=%b exp=0", busy); end
    wait_done(W + 8, n, got);
    n_checks++; if (got) begin n_fail++; $display("FAIL cancel_no_done got done after %0d exp none", n); end
    n_checks++; if (hi !== 32'hA || lo !== 32'hB)
      begin n_fail++; $display("FAIL cancel_hilo got=%h_%h exp=0000000a_0000000b", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int n; bit got; logic [2*W-1:0] e;
    logic [2:0] o; logic [W-1:0] x, y; int lat;
    exp_q.push_back(model(3'd2, 32'd1000, -32'sd3));
    do_issue(3'd2, 32'd1000, -32'sd3);
    repeat (4) @(posedge clk);
    #1;
    // start while busy must be ignored
    start = 1'b1; op = 3'd1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    wait_done(W + 8, n, got);
    n_checks++; if (!got || n + 5 != W)
      begin n_fail++; $display("FAIL ignore_latency got=%0d done=%b exp=%0d", n + 5, got, W); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    n_checks++; if ({hi, lo} !== e)
      begin n_fail++; $display("FAIL ignore_result got=%h_%h exp=%h_%h", hi, lo, e[63:32], e[31:0]); end
    // each request issued in the previous one's done cycle
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 5) ? 32'h0 : $urandom;
      if (i[0]) y = y >> $urandom_range(0, 31);
      lat = (o < 3'd2) ? MS : ((y == 32'h0) ? 1 : W);
      exp_q.push_back(model(o, x, y));
      run_op($sformatf("b2b%0d", i), o, x, y, lat);
    end
  endtask

  task automatic test_reset_mid_div;
    int n; bit got;
    do_issue(3'd2, 32'd12345, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0)
      begin n_fail++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_ctrl got busy=%b done=%b exp 0 0", busy, done); end
    wait_done(W + 8, n, got);
    n_checks++; if (got) begin n_fail++; $display("FAIL rst_mid_no_done got done after %0d exp none", n); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div0();
    test_mt_cancel();
    test_back_to_back();
    test_reset_mid_div();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
